// File: rtl/state_sequence_monitor_if.sv
// Bus between the sequencer side (state samples, clear) and the sequence monitor (status/debug).
// Handshake: state_in is sampled on a rising clock edge only when state_valid=1; there is no backpressure.
interface state_sequence_monitor_if #(
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
);
   logic [1:0]       state_in;
   logic             state_valid;
   logic             clear;
   logic             locked;
   logic             in_fault;
   logic             cycle_done;
   logic [CNT_W-1:0] cycle_count;
   logic             error;
   logic [ERR_W-1:0] err_count;
   logic [1:0]       err_expected;
   logic [1:0]       err_got;
   logic [1:0]       dbg_state;

   modport master (
      output state_in, state_valid, clear,
      input  locked, in_fault, cycle_done, cycle_count, error,
             err_count, err_expected, err_got, dbg_state
   );

   modport slave (
      input  state_in, state_valid, clear,
      output locked, in_fault, cycle_done, cycle_count, error,
             err_count, err_expected, err_got, dbg_state
   );
endinterface

// File: rtl/state_sequence_monitor.sv
// Checks the IDLE->START->RUN->STOP sequencer state bus: locks at IDLE, counts
// completed cycles, and flags/captures/counts out-of-order transitions.
module state_sequence_monitor #(
   parameter int CNT_W      = 16,
   parameter int ERR_W      = 8,
   parameter bit ALLOW_HOLD = 1'b0
) (
   input logic                  clock,
   input logic                  reset_n,
   state_sequence_monitor_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_START = 2'b01;

   typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, FAULT = 2'd2} fsm_t;

   fsm_t             state_q, state_d;
   logic [1:0]       expected_q, expected_d;
   logic [1:0]       last_q, last_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic             error_q, error_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic [1:0]       err_exp_q, err_exp_d;
   logic [1:0]       err_got_q, err_got_d;
   logic [1:0]       s;

   assign s = bus.state_in;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= SEARCH;
         expected_q    <= ST_START;
         last_q        <= ST_IDLE;
         done_q        <= 1'b0;
         cycle_count_q <= '0;
         error_q       <= 1'b0;
         err_count_q   <= '0;
         err_exp_q     <= 2'b00;
         err_got_q     <= 2'b00;
      end else begin
         state_q       <= state_d;
         expected_q    <= expected_d;
         last_q        <= last_d;
         done_q        <= done_d;
         cycle_count_q <= cycle_count_d;
         error_q       <= error_d;
         err_count_q   <= err_count_d;
         err_exp_q     <= err_exp_d;
         err_got_q     <= err_got_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      last_d     = last_q;
      done_d     = 1'b0;
      // Clear lands first so a same-edge event starts from zeroed status.
      cycle_count_d = bus.clear ? '0    : cycle_count_q;
      error_d       = bus.clear ? 1'b0  : error_q;
      err_count_d   = bus.clear ? '0    : err_count_q;
      err_exp_d     = bus.clear ? 2'b00 : err_exp_q;
      err_got_d     = bus.clear ? 2'b00 : err_got_q;

      if (bus.state_valid) begin
         case (state_q)
            SEARCH, FAULT: begin
               if (s == ST_IDLE) begin
                  state_d    = TRACK;
                  expected_d = ST_START;
                  last_d     = ST_IDLE;
               end
            end
            TRACK: begin
               if (s == expected_q) begin
                  last_d     = s;
                  expected_d = s + 2'd1;
                  if (s == ST_IDLE) begin
                     done_d        = 1'b1;
                     cycle_count_d = cycle_count_d + 1'b1;
                  end
               end else if (ALLOW_HOLD && (s == last_q)) begin
                  state_d = TRACK;
               end else begin
                  state_d = FAULT;
                  if (!error_d) begin
                     err_exp_d = expected_q;
                     err_got_d = s;
                  end
                  error_d = 1'b1;
                  if (err_count_d != {ERR_W{1'b1}})
                     err_count_d = err_count_d + 1'b1;
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   assign bus.locked       = (state_q == TRACK);
   assign bus.in_fault     = (state_q == FAULT);
   assign bus.cycle_done   = done_q;
   assign bus.cycle_count  = cycle_count_q;
   assign bus.error        = error_q;
   assign bus.err_count    = err_count_q;
   assign bus.err_expected = err_exp_q;
   assign bus.err_got      = err_got_q;
   assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_state_sequence_monitor.sv
// Directed bench for state_sequence_monitor: three instances (default, hold-allowed,
// narrow counters) share one driver and one queue-based scoreboard.
module tb_state_sequence_monitor;
   typedef struct packed {
      logic [1:0]  d;
      logic        lk;
      logic        flt;
      logic        dn;
      logic [15:0] cnt;
      logic        er;
      logic [7:0]  ec;
      logic [1:0]  ee;
      logic [1:0]  eg;
   } exp_t;
   localparam int W = $bits(exp_t);

   logic clock;
   logic reset_n;
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   state_sequence_monitor_if #(.CNT_W(16), .ERR_W(8)) bus0();
   state_sequence_monitor_if #(.CNT_W(16), .ERR_W(8)) bus1();
   state_sequence_monitor_if #(.CNT_W(2),  .ERR_W(2)) bus2();

   state_sequence_monitor #(.CNT_W(16), .ERR_W(8), .ALLOW_HOLD(1'b0)) dut0 (
      .clock(clock), .reset_n(reset_n), .bus(bus0.slave));
   state_sequence_monitor #(.CNT_W(16), .ERR_W(8), .ALLOW_HOLD(1'b1)) dut1 (
      .clock(clock), .reset_n(reset_n), .bus(bus1.slave));
   state_sequence_monitor #(.CNT_W(2),  .ERR_W(2), .ALLOW_HOLD(1'b0)) dut2 (
      .clock(clock), .reset_n(reset_n), .bus(bus2.slave));

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // driver tasks
   task automatic drive(input int d, input bit v, input logic [1:0] s, input bit clr);
      bus0.state_valid = 1'b0; bus0.state_in = 2'b00; bus0.clear = 1'b0;
      bus1.state_valid = 1'b0; bus1.state_in = 2'b00; bus1.clear = 1'b0;
      bus2.state_valid = 1'b0; bus2.state_in = 2'b00; bus2.clear = 1'b0;
      case (d)
         0: begin bus0.state_valid = v; bus0.state_in = s; bus0.clear = clr; end
         1: begin bus1.state_valid = v; bus1.state_in = s; bus1.clear = clr; end
         default: begin bus2.state_valid = v; bus2.state_in = s; bus2.clear = clr; end
      endcase
   endtask

   task automatic step(input int d, input bit v, input logic [1:0] s, input bit clr,
                       input bit lk, input bit flt, input bit dn, input int cnt,
                       input bit er, input int ec, input logic [1:0] ee, input logic [1:0] eg);
      exp_t e;
      @(negedge clock);
      drive(d, v, s, clr);
      @(posedge clock);
      #1;
      drive(d, 1'b0, 2'b00, 1'b0);
      e.d = 2'(d); e.lk = lk; e.flt = flt; e.dn = dn; e.cnt = 16'(cnt);
      e.er = er; e.ec = 8'(ec); e.ee = ee; e.eg = eg;
      exp_q.push_back(e);
   endtask

   // One full START,RUN,STOP,IDLE pass while locked.
   task automatic tail(input int d, input int c0, input int c1, input bit er,
                       input int ec, input logic [1:0] ee, input logic [1:0] eg);
      step(d, 1, 2'b01, 0, 1, 0, 0, c0, er, ec, ee, eg);
      step(d, 1, 2'b10, 0, 1, 0, 0, c0, er, ec, ee, eg);
      step(d, 1, 2'b11, 0, 1, 0, 0, c0, er, ec, ee, eg);
      step(d, 1, 2'b00, 0, 1, 0, 1, c1, er, ec, ee, eg);
   endtask

   // scoreboard
   task automatic cmp(input string name, input int d, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL dut%0d %s: got %0h expected %0h at %0t", d, name, act, req, $time);
      end
   endtask

   task automatic check(input exp_t e);
      logic lk, flt, dn, er;
      logic [15:0] cnt;
      logic [7:0] ec;
      logic [1:0] ee, eg;
      case (e.d)
         2'd0: begin
            lk = bus0.locked; flt = bus0.in_fault; dn = bus0.cycle_done; cnt = bus0.cycle_count;
            er = bus0.error; ec = bus0.err_count; ee = bus0.err_expected; eg = bus0.err_got;
         end
         2'd1: begin
            lk = bus1.locked; flt = bus1.in_fault; dn = bus1.cycle_done; cnt = bus1.cycle_count;
            er = bus1.error; ec = bus1.err_count; ee = bus1.err_expected; eg = bus1.err_got;
         end
         default: begin
            lk = bus2.locked; flt = bus2.in_fault; dn = bus2.cycle_done; cnt = {14'd0, bus2.cycle_count};
            er = bus2.error; ec = {6'd0, bus2.err_count}; ee = bus2.err_expected; eg = bus2.err_got;
         end
      endcase
      cmp("locked",       int'(e.d), 16'(lk),  16'(e.lk));
      cmp("in_fault",     int'(e.d), 16'(flt), 16'(e.flt));
      cmp("cycle_done",   int'(e.d), 16'(dn),  16'(e.dn));
      cmp("cycle_count",  int'(e.d), cnt,      e.cnt);
      cmp("error",        int'(e.d), 16'(er),  16'(e.er));
      cmp("err_count",    int'(e.d), 16'(ec),  16'(e.ec));
      cmp("err_expected", int'(e.d), 16'(ee),  16'(e.ee));
      cmp("err_got",      int'(e.d), 16'(eg),  16'(e.eg));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() != 0) begin
            e = exp_t'(exp_q.pop_front());
            check(e);
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clock);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
      end
   endtask

   task automatic check_zero(input int d);
      exp_t z;
      z = '0;
      z.d = 2'(d);
      check(z);
   endtask

   // stimulus
   initial begin
      reset_n = 1'b0;
      drive(0, 0, 2'b00, 0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      for (int d = 0; d < 3; d++) check_zero(d);
      reset_n = 1'b1;
      @(negedge clock);
      for (int d = 0; d < 3; d++) check_zero(d);

      // dut1: no lock before IDLE, then hold is a legal stall
      step(1, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      step(1, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      step(1, 1, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      step(1, 1, 2'b01, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      step(1, 1, 2'b10, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      step(1, 1, 2'b11, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      step(1, 1, 2'b00, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00);
      step(1, 1, 2'b01, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
      step(1, 1, 2'b01, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
      step(1, 1, 2'b10, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
      step(1, 1, 2'b11, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
      step(1, 1, 2'b00, 0, 1, 0, 1, 2, 0, 0, 2'b00, 2'b00);

      // dut0: 12 samples of the normal sequence
      step(0, 1, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      tail(0, 0, 1, 0, 0, 2'b00, 2'b00);
      tail(0, 1, 2, 0, 0, 2'b00, 2'b00);
      step(0, 1, 2'b01, 0, 1, 0, 0, 2, 0, 0, 2'b00, 2'b00);
      step(0, 1, 2'b10, 0, 1, 0, 0, 2, 0, 0, 2'b00, 2'b00);
      step(0, 1, 2'b11, 0, 1, 0, 0, 2, 0, 0, 2'b00, 2'b00);
      // invalid sample must be ignored
      step(0, 0, 2'b00, 0, 1, 0, 0, 2, 0, 0, 2'b00, 2'b00);
      step(0, 1, 2'b00, 0, 1, 0, 1, 3, 0, 0, 2'b00, 2'b00);
      // skip RUN: fault, single count per episode, relock without cycle_done
      step(0, 1, 2'b01, 0, 1, 0, 0, 3, 0, 0, 2'b00, 2'b00);
      step(0, 1, 2'b11, 0, 0, 1, 0, 3, 1, 1, 2'b10, 2'b11);
      step(0, 1, 2'b11, 0, 0, 1, 0, 3, 1, 1, 2'b10, 2'b11);
      step(0, 1, 2'b01, 0, 0, 1, 0, 3, 1, 1, 2'b10, 2'b11);
      step(0, 1, 2'b00, 0, 1, 0, 0, 3, 1, 1, 2'b10, 2'b11);
      tail(0, 3, 4, 1, 1, 2'b10, 2'b11);
      tail(0, 4, 5, 1, 1, 2'b10, 2'b11);
      // clear on the completing edge: count restarts at 1, error status wiped
      step(0, 1, 2'b01, 0, 1, 0, 0, 5, 1, 1, 2'b10, 2'b11);
      step(0, 1, 2'b10, 0, 1, 0, 0, 5, 1, 1, 2'b10, 2'b11);
      step(0, 1, 2'b11, 0, 1, 0, 0, 5, 1, 1, 2'b10, 2'b11);
      step(0, 1, 2'b00, 1, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00);

      // dut2: hold is an error without ALLOW_HOLD
      step(2, 1, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      step(2, 1, 2'b01, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      step(2, 1, 2'b01, 0, 0, 1, 0, 0, 1, 1, 2'b10, 2'b01);
      step(2, 1, 2'b00, 0, 1, 0, 0, 0, 1, 1, 2'b10, 2'b01);
      // 2-bit cycle counter wraps
      tail(2, 0, 1, 1, 1, 2'b10, 2'b01);
      tail(2, 1, 2, 1, 1, 2'b10, 2'b01);
      tail(2, 2, 3, 1, 1, 2'b10, 2'b01);
      tail(2, 3, 0, 1, 1, 2'b10, 2'b01);
      // five fault episodes: 2-bit err_count saturates at 3, capture kept
      step(2, 1, 2'b10, 0, 0, 1, 0, 0, 1, 2, 2'b10, 2'b01);
      step(2, 1, 2'b00, 0, 1, 0, 0, 0, 1, 2, 2'b10, 2'b01);
      step(2, 1, 2'b10, 0, 0, 1, 0, 0, 1, 3, 2'b10, 2'b01);
      step(2, 1, 2'b00, 0, 1, 0, 0, 0, 1, 3, 2'b10, 2'b01);
      step(2, 1, 2'b10, 0, 0, 1, 0, 0, 1, 3, 2'b10, 2'b01);
      step(2, 1, 2'b00, 0, 1, 0, 0, 0, 1, 3, 2'b10, 2'b01);
      step(2, 1, 2'b10, 0, 0, 1, 0, 0, 1, 3, 2'b10, 2'b01);
      step(2, 1, 2'b00, 0, 1, 0, 0, 0, 1, 3, 2'b10, 2'b01);
      step(2, 1, 2'b10, 0, 0, 1, 0, 0, 1, 3, 2'b10, 2'b01);
      step(2, 1, 2'b00, 0, 1, 0, 0, 0, 1, 3, 2'b10, 2'b01);
      // clear with an error on the same edge: fresh capture, count 1
      step(2, 1, 2'b10, 1, 0, 1, 0, 0, 1, 1, 2'b01, 2'b10);
      // clear alone leaves the FSM in FAULT
      step(2, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);

      // dut0: reset mid-RUN
      step(0, 1, 2'b01, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
      step(0, 1, 2'b10, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
      drain();
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_zero(0);
      cmp("dbg_state", 0, 16'(bus0.dbg_state), 16'd0);
      @(negedge clock);
      reset_n = 1'b1;
      // back in SEARCH: a non-IDLE sample is ignored
      step(0, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
